// File: rtl/mau_pkg.sv
// mau_pkg: shared types and defaults for the memory access unit.
//   mau_state_t    : sequencer state encoding (IDLE, CMD, RSP)
//   MAU_WORD_WIDTH : default data/address width, matches the register file
package mau_pkg;

  localparam int unsigned MAU_WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2
  } mau_state_t;

endpackage

// File: rtl/mau_timeout_cnt.sv
// mau_timeout_cnt: response-wait watchdog for the memory access unit.
// Only instantiated when MAU_TIMEOUT_EN is defined.
//   clk_i, arst_i : clock, asynchronous active-high reset
//   clear_i       : restart the count (entry to the response phase)
//   count_en_i    : one more cycle spent waiting without a response
//   expired_o     : this waiting cycle is the TIMEOUT_CYCLES-th one
module mau_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count saturates one short of the limit; the cycle that would reach
  // the limit raises expired_o so the FSM can leave on that same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = count_en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: core load/store port between the register file and the
// system bus. One transaction at a time: request accept, bus command
// handshake, then response. Last good load word is held on rdata_o.
// Optional build macro MAU_TIMEOUT_EN adds a response-wait watchdog.
//   clk_i, arst_i       : clock, asynchronous active-high reset
//   req_*_i, addr_i,
//   wdata_i, req_ready_o: request side (address/data from register file)
//   done_o, err_o       : one-cycle completion / failure pulses
//   rdata_o             : last successfully loaded word
//   bus_cmd_*, bus_addr_o, bus_wdata_o, bus_we_o : bus command channel
//   bus_rsp_valid_i, bus_rdata_i, bus_err_i       : bus response channel
//
// state | meaning
// IDLE  | ready for a request; latches address/data/we on accept
// CMD   | command presented on the bus, waiting for bus_cmd_ready_i
// RSP   | command accepted, waiting for bus_rsp_valid_i (or timeout)
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = MAU_WORD_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  req_ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  bus_cmd_valid_o,
  input  logic                  bus_cmd_ready_i,
  output logic [WORD_WIDTH-1:0] bus_addr_o,
  output logic [WORD_WIDTH-1:0] bus_wdata_o,
  output logic                  bus_we_o,
  input  logic                  bus_rsp_valid_i,
  input  logic [WORD_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_err_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT_CYCLES must be >= 1");
  end

  mau_state_t            state_q, state_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  we_q, we_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  timeout_expired;

`ifdef MAU_TIMEOUT_EN
  mau_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .clear_i    ((state_q == CMD) && bus_cmd_ready_i),
    .count_en_i ((state_q == RSP) && !bus_rsp_valid_i),
    .expired_o  (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d      = addr_i;
          wdata_d     = wdata_i;
          we_d        = req_write_i;
          cmd_valid_d = 1'b1;
          state_d     = CMD;
        end
      end
      CMD: begin
        if (bus_cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = RSP;
        end
      end
      RSP: begin
        // A response on the watchdog's last cycle still counts as normal.
        if (bus_rsp_valid_i) begin
          done_d  = 1'b1;
          err_d   = bus_err_i;
          state_d = IDLE;
          if (!we_q && !bus_err_i) begin
            rdata_d = bus_rdata_i;
          end
        end else if (timeout_expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cmd_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o     = (state_q == IDLE);
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign rdata_o         = rdata_q;
  assign bus_cmd_valid_o = cmd_valid_q;
  assign bus_addr_o      = addr_q;
  assign bus_wdata_o     = wdata_q;
  assign bus_we_o        = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit. Transactions are described by their timing
// (command stall, response wait); the expected outputs for every cycle follow
// from that timeline. Compatible with or without MAU_TIMEOUT_EN (limit 4).
module tb_mem_access_unit;

  localparam int W  = 16;
  localparam int TO = 4;

  logic         clk_i = 1'b0;
  logic         arst_i;
  logic         req_valid_i, req_write_i;
  logic [W-1:0] addr_i, wdata_i;
  logic         req_ready_o, done_o, err_o;
  logic [W-1:0] rdata_o;
  logic         bus_cmd_valid_o, bus_cmd_ready_i;
  logic [W-1:0] bus_addr_o, bus_wdata_o;
  logic         bus_we_o;
  logic         bus_rsp_valid_i;
  logic [W-1:0] bus_rdata_i;
  logic         bus_err_i;

  mem_access_unit #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .req_ready_o(req_ready_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .bus_cmd_valid_o(bus_cmd_valid_o), .bus_cmd_ready_i(bus_cmd_ready_i),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_we_o(bus_we_o),
    .bus_rsp_valid_i(bus_rsp_valid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // expected view of the outputs for the current cycle
  logic         exp_ready = 1'b1, exp_cmd_valid = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  logic [W-1:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic         exp_we = 1'b0;
  logic         chk_en = 1'b0;

  // literal pins, valid for one cycle
  logic         lit_en = 1'b0;
  logic [W-1:0] lit_rdata;
  logic         lit_done, lit_err;
  int           lit_lat = -1;

  // outputs captured while reset is held
  logic         async_en = 1'b0;
  logic         snap_ready, snap_cv, snap_done;
  logic [W-1:0] snap_rdata;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (async_en) begin
      cmp("rst_ready", 32'(snap_ready), 32'd1);
      cmp("rst_cmd_valid", 32'(snap_cv), 32'd0);
      cmp("rst_done", 32'(snap_done), 32'd0);
      cmp("rst_rdata", 32'(snap_rdata), 32'd0);
    end
    if (!arst_i && chk_en) begin
      cmp("req_ready", 32'(req_ready_o), 32'(exp_ready));
      cmp("cmd_valid", 32'(bus_cmd_valid_o), 32'(exp_cmd_valid));
      cmp("done", 32'(done_o), 32'(exp_done));
      cmp("err", 32'(err_o), 32'(exp_err));
      cmp("rdata", 32'(rdata_o), 32'(exp_rdata));
      cmp("bus_addr", 32'(bus_addr_o), 32'(exp_addr));
      cmp("bus_wdata", 32'(bus_wdata_o), 32'(exp_wdata));
      cmp("bus_we", 32'(bus_we_o), 32'(exp_we));
    end
    if (lit_en) begin
      cmp("lit_rdata_dut", 32'(rdata_o), 32'(lit_rdata));
      cmp("lit_rdata_model", 32'(exp_rdata), 32'(lit_rdata));
      cmp("lit_done", 32'(done_o), 32'(lit_done));
      cmp("lit_err", 32'(err_o), 32'(lit_err));
      if (lit_lat >= 0) cmp("lit_latency", 32'(lit_lat), 32'd3);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic pin(input logic [W-1:0] rd, input logic dn, input logic er, input int lat);
    lit_rdata = rd; lit_done = dn; lit_err = er; lit_lat = lat; lit_en = 1'b1;
  endtask

  // requester keeps poking (or holds) while the unit is busy
  task automatic busy_noise(input logic hold);
    req_valid_i = hold ? 1'b1 : 1'($urandom);
    req_write_i = 1'($urandom);
    addr_i      = W'($urandom);
    wdata_i     = W'($urandom);
  endtask

  task automatic idle_step(input logic stray);
    req_valid_i     = 1'b0;
    bus_rsp_valid_i = stray;
    bus_rdata_i     = W'($urandom);
    bus_err_i       = 1'($urandom);
    step();
    exp_done = 1'b0; exp_err = 1'b0;
    bus_rsp_valid_i = 1'b0;
  endtask

  // cd: cycles cmd_ready is held low; rd: response-phase cycles without response
  task automatic do_txn(input logic wr, input logic [W-1:0] a, input logic [W-1:0] d,
                        input int cd, input int rd, input logic [W-1:0] rsp_data,
                        input logic rsp_err, input logic hold);
    logic to;
    to = 1'b0;
`ifdef MAU_TIMEOUT_EN
    to = (rd >= TO);
`endif
    req_valid_i = 1'b1; req_write_i = wr; addr_i = a; wdata_i = d;
    bus_cmd_ready_i = 1'($urandom);
    bus_rsp_valid_i = 1'($urandom);
    bus_rdata_i = W'($urandom); bus_err_i = 1'($urandom);
    step();
    exp_ready = 1'b0; exp_cmd_valid = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    exp_addr = a; exp_wdata = d; exp_we = wr;
    for (int i = 0; i < cd; i++) begin
      busy_noise(hold);
      bus_cmd_ready_i = 1'b0;
      bus_rsp_valid_i = 1'($urandom);
      bus_rdata_i = W'($urandom); bus_err_i = 1'($urandom);
      step();
    end
    busy_noise(hold);
    bus_cmd_ready_i = 1'b1;
    bus_rsp_valid_i = 1'($urandom);
    step();
    exp_cmd_valid = 1'b0;
    bus_cmd_ready_i = 1'b0;
    for (int i = 0; i < (to ? TO : rd); i++) begin
      busy_noise(hold);
      bus_cmd_ready_i = 1'($urandom);
      bus_rsp_valid_i = 1'b0;
      bus_rdata_i = W'($urandom); bus_err_i = 1'($urandom);
      step();
    end
    if (!to) begin
      busy_noise(hold);
      bus_rsp_valid_i = 1'b1; bus_rdata_i = rsp_data; bus_err_i = rsp_err;
      step();
    end
    bus_rsp_valid_i = 1'b0; bus_cmd_ready_i = 1'b0; req_valid_i = 1'b0;
    exp_ready = 1'b1; exp_done = 1'b1; exp_err = to | rsp_err;
    if (!wr && !to && !rsp_err) exp_rdata = rsp_data;
  endtask

  task automatic reset_pulse();
    #2 arst_i = 1'b1;
    #1;
    snap_ready = req_ready_o; snap_cv = bus_cmd_valid_o;
    snap_done = done_o; snap_rdata = rdata_o;
    async_en = 1'b1;
    exp_ready = 1'b1; exp_cmd_valid = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_we = 1'b0;
    req_valid_i = 1'b0; bus_cmd_ready_i = 1'b0;
    step();
    async_en = 1'b0;
    arst_i = 1'b0;
  endtask

  initial begin
    int c0;
    arst_i = 1'b1;
    req_valid_i = 0; req_write_i = 0; addr_i = '0; wdata_i = '0;
    bus_cmd_ready_i = 0; bus_rsp_valid_i = 0; bus_rdata_i = '0; bus_err_i = 0;
    #3;
    snap_ready = req_ready_o; snap_cv = bus_cmd_valid_o;
    snap_done = done_o; snap_rdata = rdata_o;
    async_en = 1'b1;
    step();
    async_en = 1'b0;
    step();
    arst_i = 1'b0;
    chk_en = 1'b1;
    idle_step(1'b0);
    pin(16'h0000, 1'b0, 1'b0, -1);
    idle_step(1'b0);

    // basic load
    c0 = cyc;
    do_txn(1'b0, 16'h0040, 16'h0000, 0, 0, 16'hBEEF, 1'b0, 1'b0);
    pin(16'hBEEF, 1'b1, 1'b0, cyc - c0);
    idle_step(1'b0);

    // stalled store
    do_txn(1'b1, 16'h0010, 16'h1234, 4, 0, 16'h5A5A, 1'b0, 1'b0);
    pin(16'hBEEF, 1'b1, 1'b0, -1);
    idle_step(1'b0);

    // error response on a load
    do_txn(1'b0, 16'h0020, 16'h0000, 1, 1, 16'hDEAD, 1'b1, 1'b0);
    pin(16'hBEEF, 1'b1, 1'b1, -1);
    idle_step(1'b0);

    // request held through the first transaction, accepted in its done cycle
    do_txn(1'b0, 16'h0100, 16'h0000, 1, 2, 16'hC0DE, 1'b0, 1'b1);
    do_txn(1'b0, 16'h0102, 16'h0000, 0, 0, 16'hF00D, 1'b0, 1'b0);
    pin(16'hF00D, 1'b1, 1'b0, -1);
    idle_step(1'b1);
    idle_step(1'b1);
    pin(16'hF00D, 1'b0, 1'b0, -1);
    idle_step(1'b0);

    // reset while the command is pending
    req_valid_i = 1'b1; req_write_i = 1'b1; addr_i = 16'h0AAA; wdata_i = 16'h5555;
    step();
    req_valid_i = 1'b0;
    exp_ready = 1'b0; exp_cmd_valid = 1'b1; exp_addr = 16'h0AAA; exp_wdata = 16'h5555; exp_we = 1'b1;
    step();
    reset_pulse();
    idle_step(1'b0);

    // load some data, then reset while waiting for the response
    do_txn(1'b0, 16'h0200, 16'h0000, 0, 0, 16'h1357, 1'b0, 1'b0);
    idle_step(1'b0);
    req_valid_i = 1'b1; req_write_i = 1'b0; addr_i = 16'h0055; wdata_i = 16'h0000;
    step();
    req_valid_i = 1'b0;
    exp_ready = 1'b0; exp_cmd_valid = 1'b1; exp_addr = 16'h0055; exp_wdata = 16'h0000; exp_we = 1'b0;
    bus_cmd_ready_i = 1'b1;
    step();
    bus_cmd_ready_i = 1'b0;
    exp_cmd_valid = 1'b0;
    step();
    reset_pulse();
    idle_step(1'b1);
    pin(16'h0000, 1'b0, 1'b0, -1);
    idle_step(1'b0);

`ifdef MAU_TIMEOUT_EN
    do_txn(1'b0, 16'h0300, 16'h0000, 0, TO, 16'h9999, 1'b0, 1'b0);
    pin(16'h0000, 1'b1, 1'b1, -1);
    idle_step(1'b0);
    do_txn(1'b0, 16'h0302, 16'h0000, 0, TO - 1, 16'h4242, 1'b0, 1'b0);
    pin(16'h4242, 1'b1, 1'b0, -1);
    idle_step(1'b0);
`else
    do_txn(1'b0, 16'h0300, 16'h0000, 0, 12, 16'h4242, 1'b0, 1'b0);
    pin(16'h4242, 1'b1, 1'b0, -1);
    idle_step(1'b0);
`endif

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      do_txn(1'($urandom), W'($urandom), W'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
             W'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) idle_step(1'($urandom));
      end
    end
    idle_step(1'b0);
    idle_step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Core load/store port sitting between the register file and the system bus.
- Consumes the register file's read-only address/data outputs (address from ROA, store data from ROD).
- Runs one bus transaction at a time under a valid/ready command handshake plus a response phase.
- Holds the last loaded word on rdata_o, which drives the register file's main_input_i (core read input).

Parameters:
- WORD_WIDTH, 16, data and address width in bits; must equal the register file's WORD_WIDTH.
- TIMEOUT_CYCLES, 64, response wait limit; used only when MAU_TIMEOUT_EN is defined; must be >=1.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  core requests an access.
- req_write_i  in  1  1 = store, 0 = load.
- addr_i  in  WORD_WIDTH  access address, from register file ROA_o.
- wdata_i  in  WORD_WIDTH  store data, from register file ROD_o.
- req_ready_o  out  1  unit idle and accepting a request.
- done_o  out  1  one-cycle pulse: transaction finished.
- err_o  out  1  one-cycle pulse, coincident with done_o: transaction failed.
- rdata_o  out  WORD_WIDTH  last successfully loaded word; feeds register file main_input_i.
- bus_cmd_valid_o  out  1  command valid.
- bus_cmd_ready_i  in  1  bus accepts the command.
- bus_addr_o  out  WORD_WIDTH  latched address.
- bus_wdata_o  out  WORD_WIDTH  latched store data.
- bus_we_o  out  1  latched write flag.
- bus_rsp_valid_i  in  1  response valid.
- bus_rdata_i  in  WORD_WIDTH  response read data.
- bus_err_i  in  1  response error; qualified by bus_rsp_valid_i.

Behaviour:
- Reset values (asynchronous on arst_i):
  - state = IDLE.
  - rdata_o, bus_addr_o, bus_wdata_o = 0.
  - bus_we_o, bus_cmd_valid_o, done_o, err_o = 0.
  - req_ready_o = 1 immediately, since it is combinational from state.
- FSM states: IDLE, CMD, RSP.
- IDLE:
  - req_ready_o = 1.
  - If req_valid_i is sampled at a clock edge: latch addr_i, wdata_i, req_write_i into the bus_* registers and go to CMD.
- CMD:
  - bus_cmd_valid_o = 1.
  - bus_addr_o, bus_wdata_o, bus_we_o stay stable until the handshake.
  - On an edge where bus_cmd_valid_o and bus_cmd_ready_i are both high: go to RSP.
  - bus_rsp_valid_i is ignored in CMD.
- RSP:
  - bus_cmd_valid_o = 0.
  - On an edge where bus_rsp_valid_i is high: go to IDLE and register done_o = 1 for the next cycle.
  - Load with no error: rdata_o <= bus_rdata_i on that same edge.
  - Any response with bus_err_i = 1: err_o = 1 alongside done_o, and rdata_o is unchanged.
  - Store: rdata_o is unchanged; the response acts only as an acknowledgement.
- Latency:
  - Request accepted at edge E0; cmd_valid high in the following cycle.
  - With cmd_ready at E1 and rsp_valid at E2: done_o and new rdata_o are visible after E2.
  - Minimum request-to-data latency is 3 cycles.
- Back-to-back: a new request can be accepted in the same cycle done_o is high, because the state is already IDLE.
- Requests while busy: req_valid_i is ignored outside IDLE (req_ready_o = 0); the requester holds its request.
- Stray responses: bus_rsp_valid_i in IDLE is ignored.
- Reset mid-transaction: the FSM aborts to IDLE, no done_o pulse, and bus_cmd_valid_o drops asynchronously.
- rdata_o is stable between successful loads; the register file samples it at any time.

Optional Feature:
- Macro: MAU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to RSP and increments each RSP cycle without bus_rsp_valid_i.
  - When the count reaches TIMEOUT_CYCLES: go to IDLE with done_o = 1, err_o = 1, and rdata_o unchanged.
  - A response arriving on the same edge as the limit wins and is a normal completion.
- Not defined: no counter exists, and RSP waits indefinitely.

Decomposition:
- Package mau_pkg holds:
  - typedef enum logic [1:0] mau_state_t {IDLE, CMD, RSP}.
  - The default-width localparam.
- One sub-module: mau_timeout_cnt.
  - Inputs: clear, count_en. Output: expired.
  - Parameter: TIMEOUT_CYCLES.
  - Counter width $clog2(TIMEOUT_CYCLES+1).
  - Instantiated only under MAU_TIMEOUT_EN.

Test Plan:
- Basic load: load addr 0x0040; cmd_ready at once; rsp after 1 cycle with rdata 0xBEEF, err 0 -> rdata_o = 0xBEEF, single done_o pulse, err_o = 0, total 3 cycles.
- Stalled store: store addr 0x0010, wdata 0x1234; cmd_ready held low 4 cycles -> addr/wdata/we stable throughout; after ack, done_o = 1 and rdata_o keeps its previous 0xBEEF.
- Error response: load with bus_err_i = 1 and rdata 0xDEAD -> done_o = 1, err_o = 1, rdata_o unchanged.
- Busy and back-to-back: req_valid_i asserted through the whole first transaction -> second request accepted exactly in the done_o cycle; a stray rsp_valid in IDLE causes no effect.
- Reset mid-transaction: arst_i pulsed during RSP -> state IDLE, rdata_o = 0, cmd_valid = 0, no done_o; a late response is ignored.
- Timeout (MAU_TIMEOUT_EN, TIMEOUT_CYCLES = 4): no response -> done_o and err_o after 4 RSP cycles; a response on the 4th cycle completes normally with err_o = 0.
